// File: rtl/result_ascii_fmt_pkg.sv
// Shared definitions for the ASCII expression evaluator and its result formatter.
package result_ascii_fmt_pkg;

    // ASCII characters used by the evaluator and the formatter.
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;
    localparam logic [7:0] CH_EQ   = 8'h3D;

    // Default width of the evaluator result.
    localparam int RES_W = 10;

    // Formatter sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } fmt_state_t;

    // 10^n, used to prove at elaboration that NDIG digits can hold any IN_W-bit value.
    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/dd_nibble_adj.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module dd_nibble_adj (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Pure combinational correction; no carry can leave the nibble for inputs 0..9.
    always_comb begin
        o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    end

endmodule

// File: rtl/result_ascii_fmt.sv
// Binary-to-decimal ASCII formatter: sequential double-dabble conversion followed
// by a most-significant-first character stream on a valid/ready handshake.
module result_ascii_fmt
    import result_ascii_fmt_pkg::*;
#(
    parameter int IN_W        = RES_W,
    parameter int NDIG        = 4,
    parameter bit SUPPRESS_LZ = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_char,
    output logic            out_last,
    output logic            busy
);

    localparam int BCD_W = 4 * NDIG;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(NDIG - 1);

    // The digit count must cover the largest input value.
    if (pow10(NDIG) <= ((64'd1 << IN_W) - 64'd1)) begin : g_param_check
        $error("result_ascii_fmt: NDIG too small for IN_W");
    end

    fmt_state_t       r_state;
    fmt_state_t       w_state_next;
    logic [IN_W-1:0]  r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_out_valid;
    logic             r_out_last;
    logic [7:0]       r_out_char;

    logic [BCD_W-1:0] w_bcd_adj;
    logic [BCD_W-1:0] w_bcd_next;
    logic [IN_W-1:0]  w_bin_next;
    logic             w_conv_done;
    logic             w_out_fire;
    logic [IDX_W-1:0] w_idx_start;
    logic [IDX_W-1:0] w_idx_dec;
    logic [3:0]       w_dig_cur;
    logic [3:0]       w_dig_prev;

    // One correction cell per BCD digit, all applied in parallel.
    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        dd_nibble_adj u_adj (
            .i_nib (r_bcd[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    // Shift of {bcd,bin}: the binary MSB enters the BCD LSB.
    assign w_bcd_next  = {w_bcd_adj[BCD_W-2:0], r_bin[IN_W-1]};
    assign w_bin_next  = {r_bin[IN_W-2:0], 1'b0};
    assign w_conv_done = (r_state == CONV) && (r_cnt == LAST_CNT);
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_idx_dec   = r_idx - IDX_W'(1);

    // Starting digit: highest nonzero digit of the finished value, or the top digit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_idx_start = TOP_IDX;
        if (SUPPRESS_LZ) begin
            w_idx_start = '0;
            for (int i = 1; i < NDIG; i++) begin
                if (w_bcd_next[4*i +: 4] != 4'd0) begin
                    w_idx_start = IDX_W'(i);
                end
            end
        end
    end

    // Select the digit at the current index and the one below it.
    always_comb begin
        w_dig_cur  = '0;
        w_dig_prev = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_dig_cur = r_bcd[4*i +: 4];
            end
            if (w_idx_dec == IDX_W'(i)) begin
                w_dig_prev = r_bcd[4*i +: 4];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)                  w_state_next = CONV;
            CONV:    if (w_conv_done)               w_state_next = EMIT;
            EMIT:    if (w_out_fire && r_out_last)  w_state_next = IDLE;
            default:                                w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: capture, double-dabble iterations and registered character output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_char  <= 8'h00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin <= in_value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                CONV: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_conv_done) begin
                        r_idx <= w_idx_start;
                    end
                end
                EMIT: begin
                    if (!r_out_valid) begin
                        // First EMIT cycle loads the leading character.
                        r_out_valid <= 1'b1;
                        r_out_char  <= CH_0 + {4'h0, w_dig_cur};
                        r_out_last  <= (r_idx == '0);
                    end else if (out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_char  <= 8'h00;
                        end else begin
                            r_idx      <= w_idx_dec;
                            r_out_char <= CH_0 + {4'h0, w_dig_prev};
                            r_out_last <= (w_idx_dec == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_char  = r_out_char;
    assign out_last  = r_out_last;

endmodule
